// File: rtl/cv32e40p_ft_pkg.sv
// Shared types for the fault-tolerant find-first-one arbiter.
// Holds the arbiter FSM encoding and the corrected-error counter width.
package cv32e40p_ft_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam int CORR_CNT_W = 16;

endpackage

// File: rtl/cv32e40p_rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping.
// Ports: i_req (requests), i_ptr (start index) -> o_gnt (one-hot), o_idx, o_valid.
module cv32e40p_rr_pick #(
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_valid
);

    logic [IW:0] w_k;
    logic        w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 0; i < NREQ; i++) begin
            // ptr + i stays below 2*NREQ, so one conditional subtract wraps it
            w_k = {1'b0, i_ptr} + (IW+1)'(i);
            if (w_k >= (IW+1)'(NREQ)) begin
                w_k = w_k - (IW+1)'(NREQ);
            end
            if (!w_found && i_req[IW'(w_k)]) begin
                w_found          = 1'b1;
                o_gnt[IW'(w_k)]  = 1'b1;
                o_idx            = IW'(w_k);
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/cv32e40p_ff_one_ft_arbiter.sv
// Shares one TMR find-first-one unit among NREQ requesters, round-robin,
// retrying on uncorrectable voter mismatch up to MAX_RETRY times.
// Ports: req_i/data_i/gnt_o (request side), rvalid_o/rready_i/rid_o/
// first_one_o/no_ones_o/rerr_o (response), ffo_* (shared unit), alarm_o,
// corr_cnt_o. Macro CV32E40P_FF_ONE_ARB_CORR_CNT_EN enables the
// saturating corrected-error counter; otherwise corr_cnt_o is 0.
module cv32e40p_ff_one_ft_arbiter
    import cv32e40p_ft_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int LEN       = 32,
    parameter int MAX_RETRY = 2,
    localparam int IW       = $clog2(NREQ),
    localparam int RW       = $clog2(LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*LEN-1:0]   data_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [IW-1:0]         rid_o,
    output logic [RW-1:0]         first_one_o,
    output logic                  no_ones_o,
    output logic                  rerr_o,
    output logic [LEN-1:0]        ffo_in_o,
    input  logic [RW-1:0]         ffo_first_one_i,
    input  logic                  ffo_no_ones_i,
    input  logic                  ffo_err_corr_i,
    input  logic                  ffo_err_det_i,
    output logic                  alarm_o,
    output logic [CORR_CNT_W-1:0] corr_cnt_o
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;

    logic [IW-1:0]  r_ptr;
    logic [IW-1:0]  r_rid;
    logic [LEN-1:0] r_op;
    logic [2:0]     r_retry;
    logic [RW-1:0]  r_first_one;
    logic           r_no_ones;
    logic           r_rerr;
    logic           r_alarm;

    logic [NREQ-1:0] w_pick_gnt;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_vld;
    logic [LEN-1:0]  w_op_sel;
    logic            w_ue;
    logic            w_can_retry;
    logic            w_start;
    logic            w_retry;
    logic            w_done;
    logic            w_hs;

    cv32e40p_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req   (req_i),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_vld)
    );

    always_comb begin
        w_op_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_pick_gnt[k]) begin
                w_op_sel = data_i[k*LEN +: LEN];
            end
        end
    end

    // Detected but not corrected by the voter
    assign w_ue        = ffo_err_det_i & ~ffo_err_corr_i;
    assign w_can_retry = int'(r_retry) < MAX_RETRY;

    always_comb begin
        w_state_nxt = r_state;
        gnt_o       = '0;
        w_start     = 1'b0;
        w_retry     = 1'b0;
        w_done      = 1'b0;
        w_hs        = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_pick_vld) begin
                    gnt_o       = w_pick_gnt;
                    w_start     = 1'b1;
                    w_state_nxt = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                if (w_ue && w_can_retry) begin
                    w_retry = 1'b1;
                end else begin
                    w_done      = 1'b1;
                    w_state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (rready_i) begin
                    w_hs        = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_ptr       <= '0;
            r_rid       <= '0;
            r_op        <= '0;
            r_retry     <= '0;
            r_first_one <= '0;
            r_no_ones   <= 1'b0;
            r_rerr      <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_op    <= w_op_sel;
                r_rid   <= w_pick_idx;
                r_retry <= '0;
            end
            if (w_retry) begin
                r_retry <= r_retry + 3'd1;
            end
            if (w_done) begin
                r_first_one <= ffo_first_one_i;
                r_no_ones   <= ffo_no_ones_i;
                r_rerr      <= w_ue;
            end
            if (w_hs) begin
                // Next search starts just past the requester just served
                if (r_rid == IW'(NREQ-1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= r_rid + 1'b1;
                end
                if (r_rerr) begin
                    r_alarm <= 1'b1;
                end
            end
        end
    end

`ifdef CV32E40P_FF_ONE_ARB_CORR_CNT_EN
    logic [CORR_CNT_W-1:0] r_corr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_cnt <= '0;
        end else if (r_state == ARB_EXEC && ffo_err_corr_i
                     && r_corr_cnt != '1) begin
            r_corr_cnt <= r_corr_cnt + 1'b1;
        end
    end

    assign corr_cnt_o = r_corr_cnt;
`else
    assign corr_cnt_o = '0;
`endif

    assign ffo_in_o    = r_op;
    assign rvalid_o    = (r_state == ARB_RESP);
    assign rid_o       = r_rid;
    assign first_one_o = r_first_one;
    assign no_ones_o   = r_no_ones;
    assign rerr_o      = r_rerr;
    assign alarm_o     = r_alarm;

endmodule

// File: tb/tb_cv32e40p_ff_one_ft_arbiter.sv
// Directed bench for the shared FT find-first-one arbiter.
// Models the shared unit as a lowest-set-bit finder with injectable errors.
module tb_cv32e40p_ff_one_ft_arbiter;

    localparam int NREQ = 4;
    localparam int LEN  = 32;
    localparam int IW   = 2;
    localparam int RW   = 5;
`ifdef CV32E40P_FF_ONE_ARB_CORR_CNT_EN
    localparam int CORR_ON = 1;
`else
    localparam int CORR_ON = 0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_i;
    logic [NREQ*LEN-1:0] data_i;
    logic [NREQ-1:0]     gnt_o;
    logic                rvalid_o;
    logic                rready_i;
    logic [IW-1:0]       rid_o;
    logic [RW-1:0]       first_one_o;
    logic                no_ones_o;
    logic                rerr_o;
    logic [LEN-1:0]      ffo_in_o;
    logic [RW-1:0]       ffo_first_one_i;
    logic                ffo_no_ones_i;
    logic                ffo_err_corr_i;
    logic                ffo_err_det_i;
    logic                alarm_o;
    logic [15:0]         corr_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cv32e40p_ff_one_ft_arbiter #(
        .NREQ(NREQ), .LEN(LEN), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_i(req_i), .data_i(data_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rid_o(rid_o),
        .first_one_o(first_one_o), .no_ones_o(no_ones_o),
        .rerr_o(rerr_o), .ffo_in_o(ffo_in_o),
        .ffo_first_one_i(ffo_first_one_i),
        .ffo_no_ones_i(ffo_no_ones_i),
        .ffo_err_corr_i(ffo_err_corr_i),
        .ffo_err_det_i(ffo_err_det_i),
        .alarm_o(alarm_o), .corr_cnt_o(corr_cnt_o)
    );

    // Shared unit model; an all-zero operand returns 17 as its index
    always_comb begin
        ffo_first_one_i = 5'd17;
        for (int i = LEN - 1; i >= 0; i--) begin
            if (ffo_in_o[i]) ffo_first_one_i = 5'(i);
        end
        ffo_no_ones_i = (ffo_in_o == '0);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n          = 1'b0;
        req_i          = '0;
        data_i         = '0;
        rready_i       = 1'b0;
        ffo_err_det_i  = 1'b0;
        ffo_err_corr_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++;
        if ({gnt_o, rvalid_o, rid_o, first_one_o, no_ones_o, rerr_o, alarm_o}
            !== '0) begin
            n_errors++;
            $display("FAIL reset_outs got %b want 0",
                     {gnt_o, rvalid_o, rid_o, first_one_o, no_ones_o,
                      rerr_o, alarm_o});
        end
        n_checks++;
        if (corr_cnt_o !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_corr got %h want 0", corr_cnt_o);
        end
        n_checks++;
        if (ffo_in_o !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_ffo_in got %h want 0", ffo_in_o);
        end
    endtask

    task automatic test_single;
        tick();
        req_i = 4'b0001;
        data_i[0 +: LEN] = 32'h0000_0010;
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 4'b0001) begin
            n_errors++;
            $display("FAIL single_gnt got %b want 0001", gnt_o);
        end
        tick();
        req_i = '0;
        @(negedge clk);
        n_checks++;
        if ({rvalid_o, gnt_o} !== 5'b0) begin
            n_errors++;
            $display("FAIL single_t1 got %b want 00000", {rvalid_o, gnt_o});
        end
        n_checks++;
        if (ffo_in_o !== 32'h10) begin
            n_errors++;
            $display("FAIL single_ffo_in got %h want 10", ffo_in_o);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({rvalid_o, rid_o, first_one_o, no_ones_o, rerr_o}
            !== {1'b1, 2'd0, 5'd4, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL single_resp got v%b id%0d fo%0d no%b e%b want v1 id0 fo4 no0 e0",
                     rvalid_o, rid_o, first_one_o, no_ones_o, rerr_o);
        end
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rvalid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL single_after_hs got %b want 0", rvalid_o);
        end
    endtask

    task automatic test_fairness;
        int exp_id;
        logic [NREQ-1:0] exp_gnt;
        do_reset();
        tick();
        req_i = 4'b1111;
        data_i = {32'h800, 32'h400, 32'h200, 32'h100};
        rready_i = 1'b1;
        exp_id = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            exp_gnt = (c % 3 == 0) ? NREQ'(1 << exp_id) : '0;
            n_checks++;
            if (gnt_o !== exp_gnt) begin
                n_errors++;
                $display("FAIL fair_gnt c%0d got %b want %b", c, gnt_o, exp_gnt);
            end
            n_checks++;
            if (rvalid_o !== (c % 3 == 2)) begin
                n_errors++;
                $display("FAIL fair_rvalid c%0d got %b want %b",
                         c, rvalid_o, (c % 3 == 2));
            end
            if (c % 3 == 2) begin
                n_checks++;
                if ({rid_o, first_one_o} !== {IW'(exp_id), RW'(8 + exp_id)}) begin
                    n_errors++;
                    $display("FAIL fair_resp c%0d got id%0d fo%0d want id%0d fo%0d",
                             c, rid_o, first_one_o, exp_id, 8 + exp_id);
                end
                exp_id = (exp_id + 1) % NREQ;
            end
        end
        tick();
        req_i = '0;
        rready_i = 1'b0;
    endtask

    task automatic test_retry_recover;
        tick();
        req_i = 4'b0100;
        data_i[2*LEN +: LEN] = 32'h8000_0000;
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 4'b0100) begin
            n_errors++;
            $display("FAIL rec_gnt got %b want 0100", gnt_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            req_i = '0;
            ffo_err_det_i = (i < 2);
            @(negedge clk);
            n_checks++;
            if ({rvalid_o, gnt_o} !== 5'b0) begin
                n_errors++;
                $display("FAIL rec_exec%0d got %b want 00000", i, {rvalid_o, gnt_o});
            end
        end
        tick();
        ffo_err_det_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rvalid_o, rid_o, first_one_o, rerr_o, alarm_o}
            !== {1'b1, 2'd2, 5'd31, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL rec_resp got v%b id%0d fo%0d e%b a%b want v1 id2 fo31 e0 a0",
                     rvalid_o, rid_o, first_one_o, rerr_o, alarm_o);
        end
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
    endtask

    task automatic test_retry_exhaust;
        tick();
        req_i = 4'b1000;
        data_i[3*LEN +: LEN] = 32'h0000_0100;
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 4'b1000) begin
            n_errors++;
            $display("FAIL exh_gnt got %b want 1000", gnt_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            req_i = '0;
            ffo_err_det_i = 1'b1;
        end
        tick();
        ffo_err_det_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rvalid_o, first_one_o, rerr_o, alarm_o}
            !== {1'b1, 5'd8, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL exh_resp got v%b fo%0d e%b a%b want v1 fo8 e1 a0",
                     rvalid_o, first_one_o, rerr_o, alarm_o);
        end
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rvalid_o, alarm_o} !== 2'b01) begin
            n_errors++;
            $display("FAIL exh_alarm got v%b a%b want v0 a1", rvalid_o, alarm_o);
        end
        tick();
        req_i = 4'b0001;
        data_i[0 +: LEN] = 32'h0000_0001;
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 4'b0001) begin
            n_errors++;
            $display("FAIL exh_wrap_gnt got %b want 0001", gnt_o);
        end
        tick();
        req_i = '0;
        tick();
        @(negedge clk);
        n_checks++;
        if ({rvalid_o, first_one_o, rerr_o, alarm_o}
            !== {1'b1, 5'd0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL exh_clean got v%b fo%0d e%b a%b want v1 fo0 e0 a1",
                     rvalid_o, first_one_o, rerr_o, alarm_o);
        end
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (alarm_o !== 1'b1) begin
            n_errors++;
            $display("FAIL exh_sticky got %b want 1", alarm_o);
        end
    endtask

    task automatic test_backpressure_corr;
        tick();
        req_i = 4'b0001;
        data_i[0 +: LEN] = 32'h0;
        tick();
        req_i = '0;
        ffo_err_corr_i = 1'b1;
        tick();
        ffo_err_corr_i = 1'b0;
        req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({rvalid_o, gnt_o, rid_o, first_one_o, no_ones_o, rerr_o}
                !== {1'b1, 4'b0, 2'd0, 5'd17, 1'b1, 1'b0}) begin
                n_errors++;
                $display("FAIL bp_hold%0d got v%b g%b id%0d fo%0d no%b e%b want v1 g0000 id0 fo17 no1 e0",
                         i, rvalid_o, gnt_o, rid_o, first_one_o, no_ones_o, rerr_o);
            end
            if (i < 4) tick();
        end
        req_i = '0;
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
        for (int j = 0; j < 2; j++) begin
            tick();
            req_i = 4'b0010;
            data_i[LEN +: LEN] = 32'h0000_0002;
            tick();
            req_i = '0;
            ffo_err_corr_i = 1'b1;
            tick();
            ffo_err_corr_i = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({rvalid_o, rid_o, first_one_o} !== {1'b1, 2'd1, 5'd1}) begin
                n_errors++;
                $display("FAIL corr_resp%0d got v%b id%0d fo%0d want v1 id1 fo1",
                         j, rvalid_o, rid_o, first_one_o);
            end
            rready_i = 1'b1;
            tick();
            rready_i = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (corr_cnt_o !== 16'(3 * CORR_ON)) begin
            n_errors++;
            $display("FAIL corr_cnt got %0d want %0d", corr_cnt_o, 3 * CORR_ON);
        end
    endtask

    task automatic test_reset_mid;
        tick();
        req_i = 4'b0100;
        data_i[2*LEN +: LEN] = 32'h0000_0040;
        tick();
        req_i = '0;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt_o, rvalid_o, rid_o, first_one_o, no_ones_o, rerr_o, alarm_o}
            !== '0) begin
            n_errors++;
            $display("FAIL midrst_outs got %b want 0",
                     {gnt_o, rvalid_o, rid_o, first_one_o, no_ones_o,
                      rerr_o, alarm_o});
        end
        n_checks++;
        if ({corr_cnt_o, ffo_in_o} !== '0) begin
            n_errors++;
            $display("FAIL midrst_regs got c%h in%h want 0", corr_cnt_o, ffo_in_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (rvalid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_noresp got %b want 0", rvalid_o);
        end
        req_i = 4'b1111;
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 4'b0001) begin
            n_errors++;
            $display("FAIL midrst_gnt got %b want 0001", gnt_o);
        end
        tick();
        req_i = '0;
        tick();
        @(negedge clk);
        n_checks++;
        if ({rvalid_o, rid_o} !== {1'b1, 2'd0}) begin
            n_errors++;
            $display("FAIL midrst_resp got v%b id%0d want v1 id0", rvalid_o, rid_o);
        end
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_retry_recover();
        test_retry_exhaust();
        test_backpressure_corr();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cv32e40p_ff_one_ft_arbiter.md
Name: cv32e40p_ff_one_ft_arbiter

Overview:
- Shares one fault-tolerant find-first-one unit (TMR ff_one plus voter) among NREQ requesters.
- Round-robin grant; operand and result are registered.
- Retries the operation on an uncorrectable voter mismatch, up to MAX_RETRY times; returns the result with an error flag.
- Sits beside the FT datapath units. It drives the shared unit's input and consumes its result/error outputs; it does not instantiate the unit.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LEN, 32, operand width; result width is $clog2(LEN).
- MAX_RETRY, 2, re-evaluations allowed after an uncorrectable mismatch (0..7).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- req_i  in  NREQ  request per requester; level, held until granted.
- data_i  in  NREQ*LEN  operand per requester; flattened, requester k at [k*LEN +: LEN].
- gnt_o  out  NREQ  one-hot grant pulse, combinational; operand sampled this cycle.
- rvalid_o  out  1  response valid.
- rready_i  in  1  response accepted.
- rid_o  out  $clog2(NREQ)  index of the requester owning the response.
- first_one_o  out  $clog2(LEN)  voted result.
- no_ones_o  out  1  voted result.
- rerr_o  out  1  response carries an uncorrectable error.
- ffo_in_o  out  LEN  operand to the shared FT unit.
- ffo_first_one_i  in  $clog2(LEN)  FT unit result.
- ffo_no_ones_i  in  1  FT unit result.
- ffo_err_corr_i  in  1  FT unit error_correct.
- ffo_err_det_i  in  1  FT unit error_detected.
- alarm_o  out  1  sticky; set on any rerr_o response, cleared only by reset.
- corr_cnt_o  out  16  corrected-error count (see Optional Feature).

Behaviour:
- Reset values: all registers 0. FSM=IDLE, rr pointer=0, gnt_o=0, rvalid_o=0, rid_o=0, first_one_o=0, no_ones_o=0, rerr_o=0, alarm_o=0, corr_cnt_o=0.
- ffo_in_o always equals the operand register, so it is 0 after reset.
- Uncorrectable condition: ue = ffo_err_det_i & ~ffo_err_corr_i.
- IDLE:
  - If any req_i: winner = first set bit at or after the rr pointer, wrapping.
  - gnt_o[winner]=1 for one cycle; operand and rid are latched; retry_cnt=0; next state EXEC.
  - No grant in any state other than IDLE.
- EXEC (one cycle per evaluation; the FT unit is combinational):
  - If ue and retry_cnt<MAX_RETRY: retry_cnt++, stay in EXEC.
  - Otherwise: register first_one/no_ones and rerr=ue; go to RESP.
  - The corrected counter increments on every EXEC cycle with ffo_err_corr_i=1.
- RESP:
  - rvalid_o=1; all response outputs stable until rready_i is sampled high.
  - On the handshake: rr pointer = rid+1 mod NREQ; go to IDLE.
  - No new grant in the handshake cycle.
  - If rerr_o=1 at the handshake, alarm_o is set.
- Latency: grant at cycle T, rvalid_o at T+2+retries minimum. Throughput is at most one operation per 3 cycles.
- Boundary conditions:
  - req_i dropping after grant does not cancel the operation.
  - A single requester is re-granted after each response.
  - NREQ-1 wraps to 0.
  - MAX_RETRY=0 means no retry; ue is reported immediately.
  - Operand all zero: no_ones_o=1, first_one_o as returned by the unit.
  - rready_i high outside RESP is ignored.
  - rst_n asserted mid-operation aborts it with no response; the pointer returns to 0.

Optional Feature:
- Macro CV32E40P_FF_ONE_ARB_CORR_CNT_EN.
- Defined: 16-bit corrected-error counter, saturating at 0xFFFF; cleared by reset only; driven on corr_cnt_o.
- Undefined: no counter flops; corr_cnt_o tied to 0; all other behaviour identical.

Decomposition:
- Shared package cv32e40p_ft_pkg holds:
  - the FSM enum arb_state_e {ARB_IDLE, ARB_EXEC, ARB_RESP};
  - the CORR_CNT_W=16 constant.
- One sub-module: cv32e40p_rr_pick.
  - Combinational: req vector plus pointer in, one-hot grant and index out.
  - Parameter NREQ.

Test Plan:
- Single request: req_i=0001, data_i[0]=0x0000_0010, clean unit → gnt_o=0001 at T; rvalid_o at T+2 with rid_o=0, first_one_o=4, no_ones_o=0, rerr_o=0.
- Fairness: req_i=1111 held, rready_i=1 → grant order 0,1,2,3,0, one grant every 3 cycles.
- Retry recovery: ue forced for the first 2 EXEC cycles, MAX_RETRY=2, data=0x8000_0000 → rvalid_o at T+4, first_one_o=31, rerr_o=0, alarm_o=0.
- Retry exhaustion: ue held high → rvalid_o at T+4 with rerr_o=1; alarm_o=1 after the handshake and stays 1 across later clean operations.
- Backpressure and corrected errors: rready_i=0 for 5 cycles in RESP → outputs stable, no grants. ffo_err_corr_i=1 in 3 operations → corr_cnt_o=3 with the macro defined, 0 without it.
- Reset mid-EXEC: rst_n pulsed low → all outputs 0 immediately; next request from requester 0 is granted first.
